// File: rtl/jtpopeye_pkg.sv
// Shared constants for the Popeye object-table DMA: default table location,
// transfer length, trigger address and the DMA state encoding.
package jtpopeye_pkg;

  localparam logic [15:0] DMA_BASE = 16'h8C00;
  localparam int          DMA_LEN  = 160;
  localparam logic [15:0] DMA_TRIG = 16'h8C00;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_REL  = 3'd4;

  // States in which the transfer still owns (or is asking for) the bus.
  function automatic logic st_busy(input logic [2:0] st);
    return (st == ST_REQ) || (st == ST_ADDR) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/jtpopeye_edge.sv
// cen-gated edge detector: pulses fall/rise during the cen cycle in which the
// input differs from its last cen-sampled value.
module jtpopeye_edge (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic last;

  // Resets high so an idle (high) blanking signal produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst)      last <= 1'b1;
    else if (cen) last <= din;
  end

  assign fall = cen &  last & ~din;
  assign rise = cen & ~last &  din;

endmodule

// File: rtl/jtpopeye_dma.sv
// Copies LEN bytes of the object table from main RAM into the object buffer
// once per frame, armed by a CPU write to TRIG and started on LVBL falling.
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter logic [15:0] BASE = DMA_BASE,
  parameter int          LEN  = DMA_LEN,
  parameter logic [15:0] TRIG = DMA_TRIG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        LVBL,
  input  logic        MEMWRO,
  input  logic [15:0] AD,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        DMCS,
  output logic [15:0] dma_addr,
  input  logic [7:0]  ram_data,
  output logic        obj_we,
  output logic [7:0]  obj_addr,
  output logic [7:0]  obj_data,
  output logic        INITEO,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  logic [2:0] state;
  logic       pending;
  logic [7:0] cnt;
  logic       lv_fall, lv_rise;
  logic       arm, start;

  jtpopeye_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .din  (LVBL),
    .fall (lv_fall),
    .rise (lv_rise)
  );

  // An arm write coinciding with the blanking edge counts as already pending.
  assign arm   = cen && MEMWRO && (AD == TRIG);
  assign start = (state == ST_IDLE) && lv_fall && (pending || arm);

  // Handshake: bus_req stays high from REQ through DATA; the RAM port is ours
  // only while bus_ack is high, so every bus-driving output is qualified by it
  // and the FSM freezes in place whenever bus_ack is low.
  assign bus_req   = st_busy(state);
  assign DMCS      = ((state == ST_ADDR) || (state == ST_DATA)) && bus_ack;
  assign obj_we    = (state == ST_DATA) && bus_ack;
  assign dma_addr  = BASE + {8'h00, cnt};
  assign INITEO    = (state == ST_IDLE) && !pending;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      cnt      <= 8'd0;
      obj_addr <= 8'd0;
      obj_data <= 8'd0;
    end else if (cen) begin
      if (arm)                          overrun <= 1'b0;
      else if (lv_rise && st_busy(state)) overrun <= 1'b1;

      if (start)    pending <= 1'b0;
      else if (arm) pending <= 1'b1;

      case (state)
        ST_IDLE: if (start) state <= ST_REQ;
        ST_REQ: begin
          if (bus_ack) begin
            cnt   <= 8'd0;
            state <= ST_ADDR;
          end
        end
        // RAM data for dma_addr is valid on the edge that leaves ADDR.
        ST_ADDR: begin
          if (bus_ack) begin
            obj_data <= ram_data;
            obj_addr <= cnt;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_ack) begin
            if (cnt == LAST) begin
              state <= ST_REL;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= ST_ADDR;
            end
          end
        end
        ST_REL:  if (!bus_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed frame sequence with randomized RAM contents; a CPU/bus model and a
// write monitor feed a queue compared against the expected object table.
module tb_jtpopeye_dma;

  localparam logic [15:0] BASE = 16'h8C00;
  localparam int          LEN  = 160;
  localparam logic [15:0] TRIG = 16'h8C00;

  logic        clk = 1'b0;
  logic        cen = 1'b0;
  logic        rst, LVBL, MEMWRO, bus_ack;
  logic [15:0] AD;
  logic [7:0]  ram_data;
  logic        bus_req, DMCS, obj_we, INITEO, overrun;
  logic [15:0] dma_addr;
  logic [7:0]  obj_addr, obj_data;
  logic [2:0]  dbg_state;

  jtpopeye_dma #(.BASE(BASE), .LEN(LEN), .TRIG(TRIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .LVBL      (LVBL),
    .MEMWRO    (MEMWRO),
    .AD        (AD),
    .bus_req   (bus_req),
    .bus_ack   (bus_ack),
    .DMCS      (DMCS),
    .dma_addr  (dma_addr),
    .ram_data  (ram_data),
    .obj_we    (obj_we),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .INITEO    (INITEO),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cen ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cen <= ~cen;

  // ---------------- main RAM model ----------------
  logic [7:0]  mem [256];
  logic [15:0] ram_off;
  assign ram_off  = dma_addr - BASE;
  assign ram_data = (ram_off < 16'd256) ? mem[ram_off[7:0]] : 8'h00;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int n_wr = 0, cen_idx = 0, first_idx = 0, last_idx = 0;
  int n_breq = 0, n_gap_viol = 0;
  int drop_at = -1, drop_left = 0, gdly = 0;
  logic gap_on = 1'b0;

  // ---------------- CPU bus model: grants 3 cen after request ----------------
  always @(negedge clk) begin
    if (cen) begin
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) begin
          gap_on  = 1'b0;
          bus_ack = 1'b1;
        end
      end else if (drop_at >= 0 && n_wr == drop_at && bus_ack) begin
        drop_at   = -1;
        drop_left = 5;
        gap_on    = 1'b1;
        bus_ack   = 1'b0;
      end else if (bus_req && !bus_ack) begin
        gdly++;
        if (gdly >= 3) begin
          bus_ack = 1'b1;
          gdly    = 0;
        end
      end else if (!bus_req && bus_ack) begin
        bus_ack = 1'b0;
        gdly    = 0;
      end
    end
  end

  // ---------------- write monitor (samples before each cen edge) ----------------
  always begin
    @(negedge clk);
    #2;
    if (cen) begin
      cen_idx++;
      if (bus_req) n_breq++;
      if (gap_on && (DMCS || obj_we)) n_gap_viol++;
      if (obj_we) begin
        if (n_wr == 0) first_idx = cen_idx;
        last_idx = cen_idx;
        got_q.push_back({obj_addr, obj_data});
        n_wr++;
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    while (!cen) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cen(input logic mw, input logic [15:0] ad, input logic lv);
    while (!cen) @(negedge clk);
    MEMWRO = mw;
    AD     = ad;
    LVBL   = lv;
    @(negedge clk);
    MEMWRO = 1'b0;
    AD     = 16'($urandom_range(0, 16'h7FFF));
  endtask

  task automatic load_mem(input bit pattern);
    for (int i = 0; i < 256; i++)
      mem[i] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom_range(0, 255));
    exp_q.delete();
    for (int i = 0; i < LEN; i++) exp_q.push_back({8'(i), mem[i]});
    got_q.delete();
    n_wr = 0;
  endtask

  task automatic wait_writes(input string tag, input int n);
    int b = 0;
    while (n_wr < n && b < 3000) begin
      tick();
      b++;
    end
    chk(tag, 32'(b < 3000), 32'd1);
  endtask

  task automatic wait_xfer(input string tag);
    int b = 0;
    while ((n_wr < LEN || bus_req || bus_ack) && b < 3000) begin
      tick();
      b++;
    end
    chk(tag, 32'(b < 3000), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_data(input string tag, input int n);
    int mism = 0;
    for (int i = 0; i < n; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    rst = 1'b1; LVBL = 1'b1; MEMWRO = 1'b0; AD = 16'h0000; bus_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_dmcs", 32'(DMCS), 32'd0);
    chk("rst_obj_we", 32'(obj_we), 32'd0);
    chk("rst_obj_addr", 32'(obj_addr), 32'd0);
    chk("rst_obj_data", 32'(obj_data), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'(BASE));
    chk("rst_initeo", 32'(INITEO), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Full transfer with the i^5A pattern.
    load_mem(1'b1);
    drive_cen(1'b1, TRIG, 1'b1);
    chk("a_armed_initeo", 32'(INITEO), 32'd0);
    repeat (3) tick();
    chk("a_no_req_before_fall", 32'(bus_req), 32'd0);
    drive_cen(1'b0, 16'h1234, 1'b0);
    wait_xfer("a_timeout");
    chk("a_count", 32'(n_wr), 32'(LEN));
    check_data("a_data", LEN);
    chk("a_span", 32'(last_idx - first_idx), 32'(2 * (LEN - 1)));
    chk("a_final_addr", 32'(dma_addr), 32'h8C9F);
    chk("a_initeo", 32'(INITEO), 32'd1);
    chk("a_overrun", 32'(overrun), 32'd0);

    // Frame with no valid arm write: near-miss address, address without strobe.
    drive_cen(1'b0, 16'h0000, 1'b1);
    drive_cen(1'b1, TRIG + 16'd1, 1'b1);
    drive_cen(1'b0, TRIG, 1'b1);
    chk("b_initeo", 32'(INITEO), 32'd1);
    n_breq = 0;
    n_wr = 0;
    drive_cen(1'b0, 16'h0000, 1'b0);
    repeat (400) tick();
    chk("b_bus_req", 32'(n_breq), 32'd0);
    chk("b_writes", 32'(n_wr), 32'd0);

    // LVBL rises mid-transfer at byte 80.
    drive_cen(1'b0, 16'h0000, 1'b1);
    load_mem(1'b0);
    drive_cen(1'b1, TRIG, 1'b1);
    drive_cen(1'b0, 16'h0000, 1'b0);
    wait_writes("c_wait80", 80);
    drive_cen(1'b0, 16'h0000, 1'b1);
    wait_xfer("c_timeout");
    chk("c_overrun", 32'(overrun), 32'd1);
    chk("c_count", 32'(n_wr), 32'(LEN));
    check_data("c_data", LEN);

    // Arm clears overrun; bus_ack gap at byte 10; re-arm while busy at byte 50.
    load_mem(1'b0);
    drop_at = 10;
    n_gap_viol = 0;
    drive_cen(1'b1, TRIG, 1'b1);
    chk("d_overrun_clr", 32'(overrun), 32'd0);
    drive_cen(1'b0, 16'h0000, 1'b0);
    wait_writes("d_wait50", 50);
    drive_cen(1'b1, TRIG, 1'b0);
    wait_xfer("d_timeout");
    chk("d_count", 32'(n_wr), 32'(LEN));
    check_data("d_data", LEN);
    chk("d_gap_seen", 32'(drop_at), 32'hFFFF_FFFF);
    chk("d_gap_quiet", 32'(n_gap_viol), 32'd0);
    chk("d_span", 32'(last_idx - first_idx), 32'(2 * (LEN - 1) + 5));
    chk("d_pending", 32'(INITEO), 32'd0);

    // Pending arm serviced on the next frame.
    load_mem(1'b0);
    drive_cen(1'b0, 16'h0000, 1'b1);
    repeat (3) tick();
    drive_cen(1'b0, 16'h0000, 1'b0);
    wait_xfer("e_timeout");
    chk("e_count", 32'(n_wr), 32'(LEN));
    check_data("e_data", LEN);
    chk("e_initeo", 32'(INITEO), 32'd1);
    chk("e_overrun", 32'(overrun), 32'd0);

    // Arm write and LVBL fall together, then reset during byte 42.
    drive_cen(1'b0, 16'h0000, 1'b1);
    load_mem(1'b0);
    repeat (3) tick();
    drive_cen(1'b1, TRIG, 1'b0);
    chk("f_same_frame_req", 32'(bus_req), 32'd1);
    chk("f_initeo", 32'(INITEO), 32'd0);
    b = 0;
    while (n_wr < 43 && b < 4000) begin
      @(negedge clk);
      #3;
      b++;
    end
    chk("f_wait42", 32'(b < 4000), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("f_rst_bus_req", 32'(bus_req), 32'd0);
    chk("f_rst_dmcs", 32'(DMCS), 32'd0);
    chk("f_rst_obj_we", 32'(obj_we), 32'd0);
    chk("f_rst_initeo", 32'(INITEO), 32'd1);
    chk("f_rst_obj_addr", 32'(obj_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_breq = 0;
    repeat (300) tick();
    chk("f_no_more_writes", 32'(n_wr), 32'd43);
    chk("f_bus_idle", 32'(n_breq), 32'd0);
    check_data("f_partial_data", 43);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
